muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit for the EX stage, beside the ALU, sequencing one shared shift/add-subtract datapath over XLEN cycles. Accepts an M-extension op (funct7 = 0000001, OP opcode) that the decoder steers away from the ALU. Holds the pipeline with a stall until the result is ready, then presents it for one cycle.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
valid_i  input  1  M-op present in EX this cycle.
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a_i  input  XLEN  rs1 value (forwarded).
op_b_i  input  XLEN  rs2 value (forwarded).
flush_i  input  1  branch/jump flush of EX; aborts the current op.
stall_o  input/output: output  1  freeze IF/ID/EX and insert a bubble into MEM.
done_o  output  1  result valid this cycle; EX may advance.
busy_o  output  1  state not IDLE.
result_o  output  XLEN  rd value; registered, stable from done_o until the next acceptance.

Behaviour:
- Reset (reset = 0, async): state IDLE, counter 0, all internal registers 0, result_o 0, done_o 0, busy_o 0. stall_o is 0 while reset is asserted.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - valid_i = 1 and flush_i = 0 accepts the op on the edge: latch funct3, the operand signs, and the operand magnitudes.
  - Signedness: a is signed for MUL/MULH/MULHSU/DIV/REM; b is signed for MUL/MULH/DIV/REM; all others unsigned.
  - Special cases go straight to DONE with result set on the acceptance edge:
    - divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a_i.
    - signed overflow (a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC with counter 0.
- CALC: one iteration per cycle. Counter increments; on counter = XLEN-1, go to FIX.
  - Multiply: shift-add over a 2*XLEN accumulator using the LSB of the multiplier.
  - Divide: restoring; shift the remainder left one, trial-subtract the divisor, set the quotient bit if non-negative.
- FIX, one cycle:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL takes the low word; MULH/MULHSU/MULHU take the high word; DIV/DIVU the quotient; REM/REMU the remainder.
  - Register into result_o, then go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. The next instruction cannot be accepted in DONE; a valid_i in the following IDLE cycle is a new op.
- Latency, from the acceptance edge E0:
  - normal op: done_o high in the cycle after E(XLEN+1), i.e. 34 cycles for XLEN = 32;
  - special case: done_o high in the cycle after E0.
- stall_o (combinational) = (IDLE & valid_i & ~flush_i) | CALC | FIX. It is 0 in DONE.
- flush_i = 1 in any state: synchronous return to IDLE on the next edge. No done_o; result_o keeps its previous value. A flush in DONE suppresses nothing, since done_o has already been seen.
- An async reset mid-CALC immediately forces IDLE and drops stall_o and busy_o.
- Arithmetic: magnitudes are XLEN-bit unsigned; |0x80000000| = 0x80000000 taken as unsigned. All negation is two's complement at 2*XLEN (product) or XLEN (quotient/remainder).
- funct3_i, op_a_i and op_b_i are ignored outside the IDLE acceptance cycle.

Decomposition:
- Shared package riscv_pkg:
  - typedef enum md_op_e for the eight funct3 codes;
  - typedef enum md_state_e {IDLE, CALC, FIX, DONE};
  - constant MULDIV_FUNCT7 = 7'b0000001.
- One sub-module: md_datapath. It holds the accumulator/remainder/quotient registers and the per-cycle add/subtract step, driven by step/load/fix strobes. The FSM, counter, stall and special-case logic stay in muldiv_sequencer.

Test Plan:
- MUL: a = 7, b = 0xFFFFFFFD (-3), valid_i held → stall_o high 33 cycles, done_o on cycle 34, result_o = 0xFFFFFFEB, stall_o 0 that cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV/REM special cases:
  - DIV 5/0 → 0xFFFFFFFF with done_o in the cycle after acceptance and a 1-cycle stall;
  - REMU 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- Signed and unsigned divide:
  - DIVU 100/7 → 14 and REMU → 2;
  - DIV -7/2 → 0xFFFFFFFD (-3) and REM → 0xFFFFFFFF (-1).
- flush_i pulsed in CALC at counter 10 → IDLE next cycle, no done_o, result_o unchanged. A following MUL 3×4 → 12 with full latency.
- reset driven low mid-CALC, asynchronously between edges → stall_o, busy_o and done_o go 0 immediately and result_o = 0. After release, DIVU 9/3 → 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: M-extension op codes, the
// multiply/divide sequencer state encoding and signedness helpers.
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_e;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    function automatic logic md_signed_a(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_signed_b(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Shared shift/add-subtract datapath for the iterative mul/div unit.
// Ports: clk, reset (async active-low); load/step/fix/spec_load strobes;
// op, op_a, op_b operands; spec_val special-case result; result (registered).
module md_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  logic            spec_load,
    input  md_op_e          op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] spec_val,
    output logic [XLEN-1:0] result
);

    md_op_e          op_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        neg_a = md_signed_a(op) & op_a[XLEN-1];
        neg_b = md_signed_b(op) & op_b[XLEN-1];
        mag_a = neg_a ? (~op_a + 1'b1) : op_a;
        mag_b = neg_b ? (~op_b + 1'b1) : op_b;
    end

    // Multiply: hi accumulates, lo holds the multiplier and shifts right.
    // Divide: hi is the partial remainder, lo shifts the dividend out and
    // the quotient bits in. One adder serves both.
    logic            div_q;
    logic [XLEN:0]   tmp;
    logic [XLEN-1:0] addend;
    logic [XLEN+1:0] add_a;
    logic [XLEN+1:0] add_b;
    logic [XLEN+1:0] sum;
    logic            ge;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    always_comb begin
        div_q   = op_q[2];
        tmp     = {hi, lo[XLEN-1]};
        addend  = lo[0] ? opnd : '0;
        add_a   = div_q ? {1'b0, tmp} : {2'b00, hi};
        add_b   = div_q ? ~{2'b00, opnd} : {2'b00, addend};
        sum     = add_a + add_b + {{(XLEN+1){1'b0}}, div_q};
        ge      = ~sum[XLEN+1];
        step_hi = div_q ? (ge ? sum[XLEN-1:0] : tmp[XLEN-1:0])
                        : sum[XLEN:1];
        step_lo = div_q ? {lo[XLEN-2:0], ge}
                        : {sum[0], lo[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f;
    logic [XLEN-1:0]   rem_f;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod   = {hi, lo};
        prod_f = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
        quo_f  = (neg_a_q ^ neg_b_q) ? (~lo + 1'b1) : lo;
        rem_f  = neg_a_q ? (~hi + 1'b1) : hi;
        case (op_q)
            MD_MUL:    fix_res = prod_f[XLEN-1:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  fix_res = prod_f[2*XLEN-1:XLEN];
            MD_DIV,
            MD_DIVU:   fix_res = quo_f;
            default:   fix_res = rem_f;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= MD_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            result  <= '0;
        end else begin
            if (load) begin
                op_q    <= op;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                hi      <= '0;
                lo      <= op[2] ? mag_a : mag_b;
                opnd    <= op[2] ? mag_b : mag_a;
            end else if (step) begin
                hi <= step_hi;
                lo <= step_lo;
            end
            if (spec_load) begin
                result <= spec_val;
            end else if (fix) begin
                result <= fix_res;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Ports: clk, reset (async active-low), valid_i, funct3_i, op_a_i, op_b_i,
// flush_i in; stall_o (comb), done_o, busy_o, result_o (registered) out.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state;
    logic [CNT_W-1:0] cnt;

    md_op_e          op;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_val;
    logic            accept;
    logic            load;
    logic            spec_load;
    logic            step;
    logic            fix;

    always_comb begin
        op      = md_op_e'(funct3_i);
        b_zero  = (op_b_i == '0);
        ovf     = (op == MD_DIV || op == MD_REM)
                & (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                & (op_b_i == '1);
        special = op[2] & (b_zero | ovf);
        // op[1] separates REM/REMU from DIV/DIVU
        if (b_zero) begin
            spec_val = op[1] ? op_a_i : '1;
        end else begin
            spec_val = op[1] ? '0 : op_a_i;
        end
        accept    = (state == IDLE) & valid_i & ~flush_i;
        load      = accept & ~special;
        spec_load = accept & special;
        step      = (state == CALC) & ~flush_i;
        fix       = (state == FIX) & ~flush_i;
    end

    assign stall_o = reset & (accept | (state == CALC) | (state == FIX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (valid_i) begin
                            cnt    <= '0;
                            busy_o <= 1'b1;
                            if (special) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    md_datapath #(
        .XLEN(XLEN)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .spec_load(spec_load),
        .op       (op),
        .op_a     (op_a_i),
        .op_b     (op_b_i),
        .spec_val (spec_val),
        .result   (result_o)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table through a
// result scoreboard, plus flush and async-reset sequences.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .funct3_i(funct3_i),
        .op_a_i  (op_a_i),
        .op_b_i  (op_b_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input string nm);
        int k;
        int nst;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        sb.push_back(exp);
        #1 chk({nm, " accept_stall"}, {31'b0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        funct3_i = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        k   = 1;
        nst = 0;
        got = 0;
        while (k < 100 && !got) begin
            if (done_o) begin
                got = 1;
            end else begin
                if (stall_o) nst++;
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: no done after %0d cycles", nm, k);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({nm, " result"}, result_o, e);
            chk({nm, " latency"}, 32'(k), 32'(lat));
            chk({nm, " stall_cycles"}, 32'(nst), 32'(lat - 1));
            chk({nm, " stall_at_done"}, {31'b0, stall_o}, 32'd0);
            @(posedge clk);
            #1;
            chk({nm, " done_one_cycle"}, {31'b0, done_o}, 32'd0);
            chk({nm, " result_hold"}, result_o, e);
        end
    endtask

    logic [31:0] prev;
    int spurious;

    initial begin
        tv[0]  = '{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "MUL_7_m3"};
        tv[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "MULH_min"};
        tv[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "MULHU_max"};
        tv[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, "MULHSU_m1_2"};
        tv[4]  = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "DIV_by0"};
        tv[5]  = '{3'b111, 32'd5, 32'd0, 32'd5, 1, "REMU_by0"};
        tv[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV_ovf"};
        tv[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "REM_ovf"};
        tv[8]  = '{3'b101, 32'd100, 32'd7, 32'd14, 34, "DIVU_100_7"};
        tv[9]  = '{3'b111, 32'd100, 32'd7, 32'd2, 34, "REMU_100_7"};
        tv[10] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "DIV_m7_2"};
        tv[11] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "REM_m7_2"};
        tv[12] = '{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, "DIV_7_m2"};
        tv[13] = '{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34, "REM_7_m2"};
        tv[14] = '{3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 34, "MULHU_m1_2"};
        tv[15] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, "DIVU_big"};
        tv[16] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "REMU_big"};
        tv[17] = '{3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "MUL_min_m1"};

        reset    = 1'b0;
        valid_i  = 1'b1;
        flush_i  = 1'b0;
        funct3_i = 3'b000;
        op_a_i   = 32'd1;
        op_b_i   = 32'd1;
        #2;
        chk("reset stall", {31'b0, stall_o}, 32'd0);
        chk("reset done", {31'b0, done_o}, 32'd0);
        chk("reset busy", {31'b0, busy_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_op(tv[i].f3, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat, tv[i].nm);
        end

        // flush at counter 10
        prev = result_o;
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        op_a_i   = 32'd5;
        op_b_i   = 32'd6;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("flush busy_before", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        chk("flush busy", {31'b0, busy_o}, 32'd0);
        chk("flush stall", {31'b0, stall_o}, 32'd0);
        chk("flush done", {31'b0, done_o}, 32'd0);
        chk("flush result", result_o, prev);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o) spurious++;
        end
        chk("flush no_done", 32'(spurious), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "MUL_3_4");

        // async reset mid-CALC
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        op_a_i   = 32'd5;
        op_b_i   = 32'd6;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset   = 1'b0;
        valid_i = 1'b1;
        #1;
        chk("areset stall", {31'b0, stall_o}, 32'd0);
        chk("areset busy", {31'b0, busy_o}, 32'd0);
        chk("areset done", {31'b0, done_o}, 32'd0);
        chk("areset result", result_o, 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        reset   = 1'b1;
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "DIVU_9_3");

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
